sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
Converts the single-outstanding SRAM-like request interface (req/wr/select/addr/wdata/addr_ok/data_ok/rdata) into single-beat AXI read and write transactions.
Sits directly downstream of the MEM-stage signal adapter, between it and the SoC AXI crossbar.
Only one transaction is in flight at a time. Once accepted, a transaction always runs to completion; the block has no abort.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 32, data width on both sides (strobe width is DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req  in  1  request valid (SRAM side)
wr  in  1  1 = write, 0 = read
select  in  4  byte enables
addr  in  ADDR_W  byte address
wdata  in  DATA_W  write data
addr_ok  out  1  request accepted; single-cycle pulse
data_ok  out  1  transaction complete; single-cycle pulse
rdata  out  DATA_W  read data; valid while data_ok=1
araddr  out  ADDR_W  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
axi_rdata  in  DATA_W  AXI R data
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
awaddr  out  ADDR_W  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
axi_wdata  out  DATA_W  AXI W data
wstrb  out  4  AXI W strobe
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready

The SoC wrapper ties off id=0, len=0, burst=INCR and wlast=1.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; arvalid, awvalid, wvalid, rready, bready, data_ok = 0; rdata = 0; aw_done and w_done flags cleared.
- Reset mid-transaction: the block drops to IDLE immediately. The AXI slave is reset by the same signal.
- States: IDLE, AR, R, AW_W, B, DONE.

IDLE:
- addr_ok = req, combinational; it is asserted only in IDLE.
- On req=1: register addr, wdata, select and wr, plus a derived size:
  - select=1111 gives size 2.
  - select=0011 or 1100 gives size 1.
  - one-hot select gives size 0.
  - Any other pattern gives size 2.
- Next state is AR if wr=0, otherwise AW_W.

AR:
- arvalid=1; araddr and arsize come from the registered copies.
- On arready=1, go to R.

R:
- rready=1.
- On rvalid=1: capture axi_rdata into rdata and go to DONE.
- rresp and rlast are ignored.

AW_W:
- awvalid=1 until the AW handshake, then aw_done=1.
- wvalid=1 until the W handshake, then w_done=1.
- The two channels are independent and may handshake in the same cycle or in any order.
- wstrb = registered select.
- Go to B in the cycle both handshakes are complete, counting a handshake that happens in the current cycle.

B:
- bready=1.
- On bvalid=1, go to DONE.
- bresp is ignored.

DONE:
- data_ok=1 for exactly one cycle.
- rdata holds its value; it is updated only when a new read is captured.
- Go to IDLE. A new req is accepted at the earliest in the cycle after DONE.

Latency and outputs:
- Minimum read latency, with arready and rvalid already high: req at cycle 0 (addr_ok), arvalid at cycle 1, rready at cycle 2, data_ok at cycle 3.
- Minimum write latency is the same, using AW_W and B.
- All AXI valid/ready outputs and data_ok are registered-state decodes with no combinational path from AXI inputs.
- Once valid is raised it is held until ready (AXI rule). Address and data do not change while valid=1.
- req changing after acceptance has no effect. Registered copies are used.

Test Plan:
- Read, zero-wait slave: req=1, wr=0, addr=0x8000_0010, select=1111; slave returns 0xDEAD_BEEF → addr_ok at cycle 0, arvalid at cycle 1 with araddr=0x8000_0010 and arsize=2, data_ok at cycle 3 with rdata=0xDEAD_BEEF.
- Read with stalls: arready low for 3 cycles, rvalid delayed 2 cycles → arvalid held steady for 4 cycles, araddr stable throughout, exactly one data_ok pulse, no second addr_ok.
- Halfword write: select=1100, wdata=0x1234_0000, awready high 2 cycles before wready → awsize=1, wstrb=1100, awvalid drops after its handshake while wvalid stays high, bready only after both handshakes, one data_ok pulse.
- Simultaneous AW/W handshake followed by bvalid 5 cycles later → state goes AW_W→B in one cycle, data_ok exactly 1 cycle after bvalid.
- Back-to-back: req held high across the data_ok cycle → second addr_ok in the cycle after DONE, never during the busy or DONE cycles.
- Reset mid-write (rst=1 during B) → next cycle state=IDLE, all valids, readies and data_ok are 0; a fresh read then completes normally.

Source files
------------

// File: rtl/sram_axi_bridge_if.sv
// Bus bundle for sram_axi_bridge.
// Carries both sides of the bridge: the SRAM-like request port (req/wr/
// select/addr/wdata in, addr_ok/data_ok/rdata out) and the single-beat AXI
// master port (AR, R, AW, W and B channels; id/len/burst/wlast are tied off
// by the SoC wrapper).
//   master : view taken by the bridge (it masters the AXI side)
//   slave  : view taken by the environment (request source + AXI slave)
interface sram_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // SRAM-like side
  logic              req;
  logic              wr;
  logic [3:0]        select;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  // AXI read channels
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] axi_rdata;
  logic              rvalid;
  logic              rready;
  // AXI write channels
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] axi_wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport master (
    input  req, wr, select, addr, wdata,
    input  arready, axi_rdata, rvalid, awready, wready, bvalid,
    output addr_ok, data_ok, rdata,
    output araddr, arsize, arvalid, rready,
    output awaddr, awsize, awvalid, axi_wdata, wstrb, wvalid, bready
  );

  modport slave (
    output req, wr, select, addr, wdata,
    output arready, axi_rdata, rvalid, awready, wready, bvalid,
    input  addr_ok, data_ok, rdata,
    input  araddr, arsize, arvalid, rready,
    input  awaddr, awsize, awvalid, axi_wdata, wstrb, wvalid, bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: turns single-outstanding SRAM-like requests into
// single-beat AXI read or write transactions. One transaction in flight;
// once accepted it always runs to completion.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - sram_axi_bridge_if.master (SRAM request side + AXI master side)
// Outputs are pure decodes of registered state, so no AXI input reaches a
// valid/ready output combinationally. addr_ok is the only combinational
// output (req gated by IDLE).
module sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  sram_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        select_q;
  logic [2:0]        size_q;
  logic              aw_done, w_done;
  logic              accept, aw_fire, w_fire;

  // AXI size from the byte-enable pattern; irregular patterns fall back to a
  // full word and rely on wstrb to mask bytes.
  function automatic logic [2:0] size_of(input logic [3:0] sel);
    case (sel)
      4'b0011, 4'b1100:                   size_of = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 3'd0;
      default:                            size_of = 3'd2;
    endcase
  endfunction

  assign accept  = (state == IDLE) && bus.req;
  assign aw_fire = (state == AW_W) && !aw_done && bus.awready;
  assign w_fire  = (state == AW_W) && !w_done  && bus.wready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == R && bus.rvalid)
        rdata_q <= bus.axi_rdata;
      // Handshake flags live only inside AW_W; outside it they are cleared
      // so the next write starts fresh.
      if (state == AW_W) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // NOTE: request copies carry no reset; they are only read after an accept
  // has loaded them, so resetting them would buy nothing.
  // Direction is not stored separately: the AR/AW_W branch taken from IDLE
  // already encodes it.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= bus.addr;
      wdata_q  <= bus.wdata;
      select_q <= bus.select;
      size_q   <= size_of(bus.select);
    end
  end

  // NOTE: every output and next-state term gets a default before the case,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    bus.addr_ok   = 1'b0;
    bus.data_ok   = 1'b0;
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.awvalid   = 1'b0;
    bus.wvalid    = 1'b0;
    bus.bready    = 1'b0;
    bus.rdata     = rdata_q;
    bus.araddr    = addr_q;
    bus.arsize    = size_q;
    bus.awaddr    = addr_q;
    bus.awsize    = size_q;
    bus.axi_wdata = wdata_q;
    bus.wstrb     = select_q;
    case (state)
      IDLE: begin
        bus.addr_ok = bus.req;
        if (bus.req) state_next = bus.wr ? AW_W : AR;
      end
      AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_next = R;
      end
      R: begin
        bus.rready = 1'b1;
        if (bus.rvalid) state_next = DONE;
      end
      AW_W: begin
        bus.awvalid = !aw_done;
        bus.wvalid  = !w_done;
        // A handshake completing this cycle counts as done.
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = B;
      end
      B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) state_next = DONE;
      end
      DONE: begin
        bus.data_ok = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: directed requests, a configurable
// AXI slave, and a scoreboard monitor that checks AR/AW/W contents and
// data_ok/rdata against expectations queued at request time.
module tb_sram_axi_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        is_read;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration: cycles of valid/ready seen before responding.
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] r_val = '0;
  int arv_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic sample;
    @(negedge clk); #1;
  endtask

  // Present a request in IDLE, queue its expectation, check acceptance and
  // then scramble the inputs so only the registered copies can be used.
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] sz, input logic [31:0] rd);
    exp_t e;
    bus.req = 1'b1; bus.wr = w; bus.select = s; bus.addr = a; bus.wdata = d;
    if (!w) r_val = rd;
    e.is_read = !w; e.addr = a; e.size = sz; e.wdata = d; e.strb = s; e.rdata = rd;
    sb.push_back(e);
    sample;
    check("addr_ok_accept", bus.addr_ok, 1);
    step;
    bus.req = 1'b0; bus.addr = 32'hFFFF_FFFC; bus.wdata = 32'h5555_5555; bus.select = 4'b0000;
  endtask

  // Waits for data_ok; busy = cycles before the DONE cycle.
  task automatic wait_done(input int budget, output int busy);
    busy = 0;
    arv_cycles = 0;
    forever begin
      sample;
      if (bus.data_ok === 1'b1) begin
        check("addr_ok_in_done", bus.addr_ok, 0);
        return;
      end
      check("addr_ok_busy", bus.addr_ok, 0);
      if (bus.arvalid === 1'b1) arv_cycles++;
      busy++;
      if (busy >= budget) begin
        check("done_timeout", bus.data_ok, 1);
        return;
      end
      step;
    end
  endtask

  // AXI slave: decisions at the falling edge from stable DUT outputs.
  initial begin : slave
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.axi_rdata = 32'h0BAD_0BAD;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    forever begin
      @(negedge clk);
      bus.arready = (bus.arvalid === 1'b1) && (ar_cnt >= ar_wait);
      ar_cnt      = (bus.arvalid === 1'b1) ? ar_cnt + 1 : 0;
      bus.rvalid  = (bus.rready === 1'b1) && (r_cnt >= r_wait);
      bus.axi_rdata = bus.rvalid ? r_val : 32'h0BAD_0BAD;
      r_cnt       = (bus.rready === 1'b1) ? r_cnt + 1 : 0;
      bus.awready = (bus.awvalid === 1'b1) && (aw_cnt >= aw_wait);
      aw_cnt      = (bus.awvalid === 1'b1) ? aw_cnt + 1 : 0;
      bus.wready  = (bus.wvalid === 1'b1) && (w_cnt >= w_wait);
      w_cnt       = (bus.wvalid === 1'b1) ? w_cnt + 1 : 0;
      bus.bvalid  = (bus.bready === 1'b1) && (b_cnt >= b_wait);
      b_cnt       = (bus.bready === 1'b1) ? b_cnt + 1 : 0;
    end
  end

  // Scoreboard monitor plus valid-hold / payload-stability checks.
  initial begin : monitor
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    exp_t e;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0;
    forever begin
      sample;
      if (p_arv && !p_arr) check("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, p_araddr});
      if (p_awv && !p_awr) check("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr)   check("w_hold",  {bus.wvalid, bus.axi_wdata}, {1'b1, p_wdata});
      if (bus.arvalid === 1'b1 && bus.arready === 1'b1) begin
        check("ar_has_txn", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          check("ar_is_read", sb[0].is_read, 1);
          check("araddr", bus.araddr, sb[0].addr);
          check("arsize", bus.arsize, sb[0].size);
        end
      end
      if (bus.awvalid === 1'b1 && bus.awready === 1'b1) begin
        check("aw_has_txn", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          check("aw_is_write", sb[0].is_read, 0);
          check("awaddr", bus.awaddr, sb[0].addr);
          check("awsize", bus.awsize, sb[0].size);
        end
      end
      if (bus.wvalid === 1'b1 && bus.wready === 1'b1) begin
        check("w_has_txn", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          check("axi_wdata", bus.axi_wdata, sb[0].wdata);
          check("wstrb", bus.wstrb, sb[0].strb);
        end
      end
      if (bus.data_ok === 1'b1) begin
        check("data_ok_has_txn", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (e.is_read) check("rdata", bus.rdata, e.rdata);
        end
      end
      p_arv = (bus.arvalid === 1'b1); p_arr = (bus.arready === 1'b1); p_araddr = bus.araddr;
      p_awv = (bus.awvalid === 1'b1); p_awr = (bus.awready === 1'b1); p_awaddr = bus.awaddr;
      p_wv  = (bus.wvalid === 1'b1);  p_wr  = (bus.wready === 1'b1);  p_wdata  = bus.axi_wdata;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check_quiet(input string tag);
    check({tag, "_valids_readies"},
          {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_ok}, 6'b0);
  endtask

  initial begin : stim
    int busy, bcnt;
    rst = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.select = '0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    sample;
    check_quiet("reset");
    check("reset_rdata", bus.rdata, 0);
    check("reset_addr_ok", bus.addr_ok, 0);
    step;
    rst = 1'b0;

    // 1: zero-wait read, minimum latency.
    issue(1'b0, 4'b1111, 32'h8000_0010, 32'h0, 3'd2, 32'hDEAD_BEEF);
    sample;
    check("t1_c1_arvalid", bus.arvalid, 1);
    check("t1_c1_araddr", bus.araddr, 32'h8000_0010);
    check("t1_c1_arsize", bus.arsize, 2);
    step; sample;
    check("t1_c2_rready", {bus.rready, bus.arvalid, bus.data_ok}, 3'b100);
    step; sample;
    check("t1_c3_data_ok", bus.data_ok, 1);
    check("t1_c3_rdata", bus.rdata, 32'hDEAD_BEEF);
    step; sample;
    check("t1_single_pulse", bus.data_ok, 0);
    step;

    // Size decode on reads: one-hot, low halfword, irregular pattern.
    issue(1'b0, 4'b0100, 32'h8000_0022, 32'h0, 3'd0, 32'h0055_0000);
    wait_done(20, busy); step;
    issue(1'b0, 4'b0011, 32'h8000_0030, 32'h0, 3'd1, 32'h0000_4321);
    wait_done(20, busy); step;
    issue(1'b0, 4'b0110, 32'h8000_0040, 32'h0, 3'd2, 32'h0BAD_F00D);
    wait_done(20, busy); step;

    // 2: read with AR and R stalls; req stays high with other contents.
    ar_wait = 3; r_wait = 2;
    issue(1'b0, 4'b1111, 32'h8000_0050, 32'h0, 3'd2, 32'hCAFE_0001);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'hFFFF_FFF0;
    wait_done(30, busy);
    bus.req = 1'b0;
    check("t2_arvalid_cycles", arv_cycles, 4);
    check("t2_busy_cycles", busy, 7);
    step; sample;
    check("t2_after_done", {bus.data_ok, bus.addr_ok}, 2'b00);
    step;
    ar_wait = 0; r_wait = 0;

    // 3: halfword write, AW accepted two cycles before W.
    w_wait = 2;
    issue(1'b1, 4'b1100, 32'h8000_0100, 32'h1234_0000, 3'd1, 32'h0);
    sample;
    check("t3_c1", {bus.awvalid, bus.wvalid, bus.bready}, 3'b110);
    check("t3_awsize", bus.awsize, 1);
    check("t3_wstrb", bus.wstrb, 4'b1100);
    step; sample;
    check("t3_c2", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    step; sample;
    check("t3_c3", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    step; sample;
    check("t3_c4", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    step; sample;
    check("t3_c5_data_ok", bus.data_ok, 1);
    check("t3_rdata_held", bus.rdata, 32'hCAFE_0001);
    step; sample;
    check("t3_single_pulse", bus.data_ok, 0);
    step;
    w_wait = 0;

    // 4: simultaneous AW/W, bvalid after 5 bready cycles.
    b_wait = 5;
    issue(1'b1, 4'b1111, 32'h8000_0200, 32'hA5A5_5A5A, 3'd2, 32'h0);
    sample;
    check("t4_c1", {bus.awvalid, bus.wvalid, bus.bready}, 3'b110);
    step; sample;
    check("t4_c2_to_b", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    bcnt = 0;
    while (bus.bvalid !== 1'b1 && bcnt < 20) begin
      bcnt++;
      step; sample;
    end
    check("t4_b_wait_cycles", bcnt, 5);
    step; sample;
    check("t4_data_ok_after_b", {bus.data_ok, bus.bready}, 2'b10);
    step; sample;
    check("t4_single_pulse", bus.data_ok, 0);
    step;
    b_wait = 0;

    // 5: back-to-back, next read held on req across the DONE cycle.
    issue(1'b1, 4'b0001, 32'h8000_0301, 32'h0000_0077, 3'd0, 32'h0);
    bus.req = 1'b1; bus.wr = 1'b0; bus.select = 4'b1111; bus.addr = 32'h8000_0400;
    wait_done(20, busy);
    check("t5_first_busy", busy, 2);
    step;
    issue(1'b0, 4'b1111, 32'h8000_0400, 32'h0, 3'd2, 32'h1357_9BDF);
    wait_done(20, busy);
    check("t5_second_busy", busy, 2);
    step;

    // 6: reset while waiting for B, then a fresh read.
    b_wait = 30;
    issue(1'b1, 4'b1111, 32'h8000_0500, 32'hFEED_0000, 3'd2, 32'h0);
    sample;
    step; sample;
    check("t6_in_b", bus.bready, 1);
    step;
    rst = 1'b1;
    sample;
    step;
    rst = 1'b0;
    sb.delete();
    sample;
    check_quiet("t6_after_rst");
    check("t6_rdata_cleared", bus.rdata, 0);
    check("t6_addr_ok", bus.addr_ok, 0);
    step;
    b_wait = 0;
    issue(1'b0, 4'b1111, 32'h8000_0600, 32'h0, 3'd2, 32'h2468_ACE0);
    wait_done(20, busy);
    check("t6_fresh_busy", busy, 2);
    step; sample;
    check("t6_single_pulse", bus.data_ok, 0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
